// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray-code helpers and geometry checks shared by both FIFO controllers
package fifo_pkg;
  localparam int GRAY_W = 32;
  typedef logic [GRAY_W-1:0] gray_word_t;
  // Operands are zero-extended into gray_word_t, so one body serves every pointer width.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic bit depth_ok(input int height, input int ptr_w);
    return height == (1 << ptr_w);
  endfunction
endpackage

// File: rtl/gray_sync_unit.sv
// gray_sync_unit: plain flop chain carrying a Gray pointer into the local clock domain
module gray_sync_unit #(
  parameter int width       = 4,
  parameter int sync_stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d_async,
  output logic [width-1:0] q_sync
);
  logic [width-1:0] r_sync [sync_stages];
  if (sync_stages < 1) begin : g_bad_stages
    $error("gray_sync_unit needs at least one stage");
  end
  // shift the asynchronous word through the chain with no logic between stages
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < sync_stages; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= d_async;
      for (int i = 1; i < sync_stages; i++) r_sync[i] <= r_sync[i-1];
    end
  assign q_sync = r_sync[sync_stages-1];
endmodule

// File: rtl/fifo_write_ctrl_unit.sv
// fifo_write_ctrl_unit: write-domain pointer, handshake and status control for the async FIFO
module fifo_write_ctrl_unit
  import fifo_pkg::*;
#(
  parameter int stk_height    = 8,
  parameter int stk_ptr_width = 3,
  parameter int sync_stages   = 2,
  parameter int af_thresh     = 6
) (
  input  logic                     clk_write,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     write_to_stk,
  output logic [stk_ptr_width-1:0] write_ptr,
  output logic [stk_ptr_width:0]   wr_ptr_gray,
  input  logic [stk_ptr_width:0]   rd_ptr_gray_async,
  output logic                     full,
  output logic                     almost_full,
  output logic [stk_ptr_width:0]   wr_level,
  output logic                     overflow
);
  localparam int N = stk_ptr_width + 1;
  localparam logic [N-1:0] FULL_MASK = N'(3) << (N - 2);
  localparam logic [N-1:0] AF_LEVEL = N'(af_thresh);
  if (!depth_ok(stk_height, stk_ptr_width)) begin : g_bad_depth
    $error("stk_height must equal 2**stk_ptr_width");
  end
  if (sync_stages < 2) begin : g_bad_sync
    $error("sync_stages must be at least 2");
  end
  if (af_thresh < 1 || af_thresh > stk_height) begin : g_bad_af
    $error("af_thresh must lie in 1..stk_height");
  end
  logic [N-1:0] r_wbin, r_wgray, r_level;
  logic         r_full, r_af, r_ovf;
  logic         w_accept;
  logic [N-1:0] w_wbin_next, w_wgray_next, w_rq_gray, w_rq_bin, w_level_next;
  logic [31:0]  w_wg32, w_rb32;
  logic         w_unused;
  // The status registers form the last synchronizer stage, so the chain itself is one flop
  // shorter and a read-pointer move shows up in full/level exactly sync_stages edges later.
  gray_sync_unit #(.width(N), .sync_stages(sync_stages - 1)) u_rq_sync (
    .clk    (clk_write),
    .rst    (rst),
    .d_async(rd_ptr_gray_async),
    .q_sync (w_rq_gray)
  );
  assign w_accept     = wr_valid & ~r_full;
  assign w_wbin_next  = r_wbin + N'(w_accept);
  assign w_wg32       = bin2gray(32'(w_wbin_next));
  assign w_rb32       = gray2bin(32'(w_rq_gray));
  assign w_wgray_next = w_wg32[N-1:0];
  assign w_rq_bin     = w_rb32[N-1:0];
  assign w_level_next = w_wbin_next - w_rq_bin;
  assign w_unused     = &{1'b0, w_wg32[31:N], w_rb32[31:N]};
  // advance the pointers on accept and register status from the next-state values
  always_ff @(posedge clk_write or negedge rst)
    if (!rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_level <= w_level_next;
      r_full  <= w_wgray_next == (w_rq_gray ^ FULL_MASK);
      r_af    <= w_level_next >= AF_LEVEL;
      r_ovf   <= wr_valid & r_full;
    end
  assign wr_ready     = ~r_full;
  assign write_to_stk = w_accept;
  assign write_ptr    = r_wbin[N-2:0];
  assign wr_ptr_gray  = r_wgray;
  assign full         = r_full;
  assign almost_full  = r_af;
  assign wr_level     = r_level;
  assign overflow     = r_ovf;
endmodule

// File: tb/tb_fifo_write_ctrl_unit.sv
// tb_fifo_write_ctrl_unit: vector table plus scoreboarded sequences for the FIFO write controller
module tb_fifo_write_ctrl_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, v, v2;
  logic [3:0] rd, rd2;
  logic rdy, wts, full, af, ovf;
  logic [2:0] wptr;
  logic [3:0] gray, lvl;
  logic rdy2, wts2, full2, af2, ovf2;
  logic [2:0] wptr2;
  logic [3:0] gray2, lvl2;
  int checks = 0;
  int failures = 0;
  fifo_write_ctrl_unit dut (
    .clk_write(clk), .rst(rst), .wr_valid(v), .wr_ready(rdy), .write_to_stk(wts),
    .write_ptr(wptr), .wr_ptr_gray(gray), .rd_ptr_gray_async(rd), .full(full),
    .almost_full(af), .wr_level(lvl), .overflow(ovf)
  );
  fifo_write_ctrl_unit #(.sync_stages(3), .af_thresh(4)) dut2 (
    .clk_write(clk), .rst(rst), .wr_valid(v2), .wr_ready(rdy2), .write_to_stk(wts2),
    .write_ptr(wptr2), .wr_ptr_gray(gray2), .rd_ptr_gray_async(rd2), .full(full2),
    .almost_full(af2), .wr_level(lvl2), .overflow(ovf2)
  );
  typedef struct {
    logic v; logic [3:0] rd; logic p_wts; logic [2:0] p_ptr;
    logic [2:0] q_ptr; logic [3:0] q_gray; logic q_full, q_af; logic [3:0] q_lvl; logic q_ovf;
  } vec_t;
  typedef struct packed {
    logic [2:0] ptr; logic [3:0] gray; logic full, af; logic [3:0] lvl; logic ovf;
  } post_t;
  vec_t tbl[15];
  post_t sb[$];
  logic [3:0] gq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(logic vi, logic [3:0] rdi, logic pw, logic [2:0] pp, logic [2:0] qp,
                              logic [3:0] qg, logic qf, logic qa, logic [3:0] ql, logic qo);
    vec_t r;
    r.v = vi; r.rd = rdi; r.p_wts = pw; r.p_ptr = pp; r.q_ptr = qp;
    r.q_gray = qg; r.q_full = qf; r.q_af = qa; r.q_lvl = ql; r.q_ovf = qo;
    return r;
  endfunction
  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    post_t e;
    logic [3:0] eg, prev;
    int cnt;
    tbl[0]  = mk(1, 4'h0, 1, 0, 1, 4'b0001, 0, 0, 1, 0);
    tbl[1]  = mk(1, 4'h0, 1, 1, 2, 4'b0011, 0, 0, 2, 0);
    tbl[2]  = mk(1, 4'h0, 1, 2, 3, 4'b0010, 0, 0, 3, 0);
    tbl[3]  = mk(1, 4'h0, 1, 3, 4, 4'b0110, 0, 0, 4, 0);
    tbl[4]  = mk(1, 4'h0, 1, 4, 5, 4'b0111, 0, 0, 5, 0);
    tbl[5]  = mk(1, 4'h0, 1, 5, 6, 4'b0101, 0, 1, 6, 0);
    tbl[6]  = mk(1, 4'h0, 1, 6, 7, 4'b0100, 0, 1, 7, 0);
    tbl[7]  = mk(1, 4'h0, 1, 7, 0, 4'b1100, 1, 1, 8, 0);
    tbl[8]  = mk(1, 4'h0, 0, 0, 0, 4'b1100, 1, 1, 8, 1);
    tbl[9]  = mk(1, 4'h0, 0, 0, 0, 4'b1100, 1, 1, 8, 1);
    tbl[10] = mk(1, 4'h0, 0, 0, 0, 4'b1100, 1, 1, 8, 1);
    tbl[11] = mk(0, 4'h0, 0, 0, 0, 4'b1100, 1, 1, 8, 0);
    tbl[12] = mk(0, 4'h1, 0, 0, 0, 4'b1100, 1, 1, 8, 0);
    tbl[13] = mk(0, 4'h1, 0, 0, 0, 4'b1100, 0, 1, 7, 0);
    tbl[14] = mk(1, 4'h1, 1, 0, 1, 4'b1101, 1, 1, 8, 0);
    rst = 1'b0; v = 1'b0; v2 = 1'b0; rd = '0; rd2 = '0;
    #1;
    chk("reset_wts_idle", wts, 0);
    v = 1'b1;
    #1;
    chk("reset_wts_follow", wts, 1);
    chk("reset_ready", rdy, 1);
    chk("reset_state", {wptr, gray, full, af, lvl, ovf}, 0);
    v = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      v = tbl[i].v; rd = tbl[i].rd;
      #1;
      chk($sformatf("row%0d_pre_wts_ptr", i), {wts, wptr}, {tbl[i].p_wts, tbl[i].p_ptr});
      sb.push_back({tbl[i].q_ptr, tbl[i].q_gray, tbl[i].q_full, tbl[i].q_af, tbl[i].q_lvl, tbl[i].q_ovf});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d_post_ptr_gray_full_af_lvl_ovf", i), {wptr, gray, full, af, lvl, ovf}, e);
    end
    @(negedge clk) begin v = 1'b0; rst = 1'b0; end
    #1 rst = 1'b1;
    cnt = 0; prev = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v = 1'b1;
      rd = g4(cnt >= 2 ? 4'((cnt - 2) % 16) : 4'h0);
      gq.push_back(g4(4'((cnt + 1) % 16)));
      @(posedge clk);
      #1;
      cnt++;
      eg = gq.pop_front();
      chk($sformatf("wrap%0d_gray", i), gray, eg);
      chk($sformatf("wrap%0d_one_bit", i), $countones(gray ^ prev), 1);
      chk($sformatf("wrap%0d_no_full", i), full, 0);
      chk($sformatf("wrap%0d_ptr", i), wptr, cnt % 8);
      prev = gray;
    end
    @(negedge clk) begin v = 1'b0; rd = '0; rst = 1'b0; end
    #1 rst = 1'b1;
    @(negedge clk) v = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("midburst_ptr", wptr, 5);
    rst = 1'b0;
    #1;
    chk("async_rst_state", {wptr, gray, full, lvl, ovf}, 0);
    chk("async_rst_wts_follow", wts, 1);
    chk("async_rst_ready", rdy, 1);
    v = 1'b0;
    #1;
    chk("async_rst_wts_idle", wts, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) v2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cfg3_af_after_%0d", k), af2, k == 4);
      if (k == 4) v2 = 1'b0;
    end
    chk("cfg3_level4", lvl2, 4);
    @(negedge clk) rd2 = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cfg3_level_edge%0d", k), lvl2, k == 3 ? 3 : 4);
    end
    chk("cfg3_af_drop", af2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_write_ctrl_unit.md
Name: fifo_write_ctrl_unit

Overview:
Write-side controller for the dual-port asynchronous FIFO. It runs entirely in the write clock domain and accepts words from the producer with a valid/ready handshake. It drives the write address and write strobe into the FIFO storage datapath, and publishes a Gray-coded write pointer for the read domain. It also synchronizes the read domain's Gray pointer to produce full, almost-full, level and overflow status.

Parameters:
stk_height, 8, FIFO depth in words; must equal 2**stk_ptr_width (checked at elaboration)
stk_ptr_width, 3, storage address width
sync_stages, 2, flops in the read-pointer synchronizer; minimum 2
af_thresh, 6, almost_full asserts when level >= af_thresh; range 1..stk_height

Ports:
clk_write  input  1  write-domain clock; the block's only clock
rst  input  1  asynchronous, active-low reset; 0 clears all state immediately
wr_valid  input  1  producer presents a word this cycle
wr_ready  output  1  block can accept a word; equals ~full
write_to_stk  output  1  storage write strobe; equals wr_valid & ~full (combinational, registered inputs only)
write_ptr  output  stk_ptr_width  storage write address; low bits of the binary write pointer
wr_ptr_gray  output  stk_ptr_width+1  registered Gray write pointer, sent to the read domain
rd_ptr_gray_async  input  stk_ptr_width+1  Gray read pointer from the read domain, asynchronous to clk_write
full  output  1  registered; FIFO holds stk_height words
almost_full  output  1  registered; level >= af_thresh
wr_level  output  stk_ptr_width+1  registered occupancy as seen by the write domain (conservative)
overflow  output  1  registered one-cycle pulse; wr_valid was high while full

Behaviour:
- Internal state: wbin (binary pointer, stk_ptr_width+1 bits), wgray, synchronizer chain, full, almost_full, wr_level, overflow.
- Reset (rst=0, asynchronous): wbin=0, wgray=0, all sync flops=0, full=0, almost_full=0, wr_level=0, overflow=0. Therefore write_ptr=0, wr_ptr_gray=0, wr_ready=1 and write_to_stk=wr_valid. The read domain must be reset in the same window.
- Accept: a word is accepted on the clk_write edge where wr_valid=1 and full=0. At that edge:
  - the storage samples data_in at write_ptr;
  - wbin_next = wbin+1, wrapping modulo 2**(stk_ptr_width+1);
  - wgray_next = wbin_next ^ (wbin_next>>1).
  With no accept, wbin_next=wbin.
- Synchronizer: rd_ptr_gray_async passes through sync_stages flops. The last stage, rq_gray, is the only read-pointer value used. rq_bin = gray2bin(rq_gray).
- Full (registered, computed from next state): full <= (wgray_next == {~rq_gray[top two bits], rq_gray[remaining bits]}). Full asserts on the same edge that accepts the stk_height-th word, so there is zero-cycle lag. It deasserts sync_stages edges after the read domain advances its pointer.
- Level: wr_level <= (wbin_next - rq_bin) mod 2**(stk_ptr_width+1). The value ranges 0..stk_height and never under-reports occupancy.
- almost_full <= (level_next >= af_thresh).
- Overflow: overflow <= wr_valid & full. The attempted word is dropped, and wbin and storage are untouched.
- Simultaneous write and read-pointer change: both apply in the same cycle. The read update is seen only after sync latency.
- Wrap-around: the extra MSB distinguishes full from empty. Pointer wrap from 2**(stk_ptr_width+1)-1 to 0 needs no special casing.
- A read pointer that is mid-transition can change by at most one Gray bit, so rq_gray is always a valid old or new value.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized on width;
  - the depth/pointer-width consistency check.
- The read-side controller reuses fifo_pkg.
- One sub-module, gray_sync_unit (params width, sync_stages; ports clk, rst, d_async, q_sync). The read controller instantiates it too.
- gray_sync_unit flops reset to 0 and carry no logic between stages.

Test Plan:
1. Reset release, then wr_valid=1 for 8 cycles with the read pointer held at 0:
   - write_ptr steps 0..7;
   - full=1 after the 8th edge, with wr_level=8 and almost_full=1 from the 6th accept;
   - wr_ptr_gray=4'b1100.
2. While full, hold wr_valid=1 for 3 cycles:
   - write_to_stk stays 0, write_ptr stays 0;
   - overflow=1 for 3 consecutive cycles, then 0 after wr_valid drops.
3. From full, step rd_ptr_gray_async 0000->0001:
   - full drops exactly 2 edges later, wr_level=7;
   - the next accept writes address 0 and full rises again.
4. Run 20 writes with the read pointer tracking 2 behind. wbin wraps 15->0, and full never asserts falsely. Check that wr_ptr_gray changes exactly one bit per accept.
5. Assert rst=0 mid-burst (at wbin=5), asynchronously between edges:
   - all outputs clear immediately: write_ptr=0, full=0, wr_level=0;
   - write_to_stk follows wr_valid.
6. Configure sync_stages=3, af_thresh=4. Write 4 words: almost_full rises on the 4th accept. A read-pointer change is reflected after exactly 3 edges.
